// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//   Owns the single write port of the register file. After reset, or on a
//   clr_req pulse while running, it writes zero to every register. Otherwise it
//   grants one writeback requester per cycle in round-robin order using a
//   valid/ready handshake, and forwards the granted write one cycle later.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   clr_req    - pulse: re-clear the register file (honoured only while running)
//   req_valid  - per-requester write request
//   req_addr   - packed addresses, requester i at [i*REG_ADDR +: REG_ADDR]
//   req_data   - packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  - one-hot combinational grant
//   wr_en      - register-file write enable (registered)
//   wr_addr    - register-file write address (registered)
//   wr_data    - register-file write data (registered)
//   init_done  - high while in the run state (registered)
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5,
    parameter int REG_CNT    = 32,
    parameter int NUM_REQ    = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr_req,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*REG_ADDR-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           wr_en,
    output logic [REG_ADDR-1:0]            wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           init_done
);

    localparam int PTR_W = $clog2(NUM_REQ);
    // One extra count value marks "all clear writes issued".
    localparam int CNT_W = $clog2(REG_CNT + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [PTR_W-1:0]        last_r;
    logic                    wr_en_r;
    logic [REG_ADDR-1:0]     wr_addr_r;
    logic [DATA_WIDTH-1:0]   wr_data_r;
    logic                    init_done_r;

    logic [NUM_REQ-1:0]      ready_s;
    logic                    gnt_found_s;
    logic [PTR_W-1:0]        gnt_idx_s;
    logic [PTR_W-1:0]        cand_s;
    logic [REG_ADDR-1:0]     sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic                    xfer_s;

    // Index base+off wrapped into 0..NUM_REQ-1 (off never exceeds NUM_REQ).
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        ready_s     = '0;
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        if (state_r == ST_RUN) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand_s = wrap_idx(last_r, k);
                if (!gnt_found_s && req_valid[cand_s]) begin
                    gnt_found_s     = 1'b1;
                    gnt_idx_s       = cand_s;
                    ready_s[cand_s] = 1'b1;
                end else begin
                    gnt_found_s = gnt_found_s;
                end
            end
        end else begin
            ready_s = '0;
        end
    end

    // Mux out the granted requester's address and data.
    always_comb begin
        sel_addr_s = req_addr[gnt_idx_s*REG_ADDR +: REG_ADDR];
        sel_data_s = req_data[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
    end

    // The grant only exists when its valid bit is set, so a grant is a transfer.
    assign xfer_s = gnt_found_s;

    // Clear sequencer, round-robin pointer and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            last_r      <= PTR_W'(NUM_REQ - 1);
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    // clr_req is deliberately ignored here: the clear in progress
                    // already covers every register.
                    if (cnt_r == CNT_W'(REG_CNT)) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                        wr_en_r     <= 1'b0;
                        cnt_r       <= '0;
                    end else begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= REG_ADDR'(cnt_r);
                        wr_data_r <= '0;
                        cnt_r     <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        last_r <= gnt_idx_s;
                        // x0 is hard-wired zero: handshake it but never write it.
                        if (sel_addr_s != '0) begin
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= sel_addr_s;
                            wr_data_r <= sel_data_s;
                        end else begin
                            wr_en_r <= 1'b0;
                        end
                    end else begin
                        wr_en_r <= 1'b0;
                    end
                    // A same-cycle grant above still completes; the clear starts
                    // on the following edge with cnt already at zero.
                    if (clr_req) begin
                        state_r     <= ST_INIT;
                        init_done_r <= 1'b0;
                        cnt_r       <= '0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= '0;
                    wr_en_r     <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//   Directed bench for regfile_wr_arbiter: reset values, the post-reset clear,
//   a table of round-robin grant vectors, and hand-written sequences for the
//   address-0 case, clr_req while running, clr_req during a clear, and an
//   asynchronous reset in the middle of a cycle.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RC = 32;
    localparam int NR = 3;

    logic              clk;
    logic              rst_n;
    logic              clr_req;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              init_done;

    int checks;
    int errors;

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] exp_ready;
        logic          exp_en;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    regfile_wr_arbiter #(
        .DATA_WIDTH (DW),
        .REG_ADDR   (AW),
        .REG_CNT    (RC),
        .NUM_REQ    (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect RC clear writes then init_done; optionally pulse clr_req at one
    // clear cycle (it must be ignored).
    task automatic check_clear_seq(input int clr_at);
        for (int c = 0; c < RC; c++) begin
            tick();
            chk("clr_wr_en",  64'(wr_en),     64'd1);
            chk("clr_addr",   64'(wr_addr),   64'(c));
            chk("clr_data",   64'(wr_data),   64'd0);
            chk("clr_done",   64'(init_done), 64'd0);
            clr_req = (c == clr_at);
            #1;
            chk("clr_ready",  64'(req_ready), 64'd0);
        end
        clr_req = 1'b0;
        tick();
        chk("run_done",  64'(init_done), 64'd1);
        chk("run_wr_en", 64'(wr_en),     64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clr_req   = 1'b0;
        req_valid = '0;
        req_addr  = {5'd7, 5'd6, 5'd5};
        req_data  = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};

        // Grant table; expectations after the edge use addresses 5/6/7, data A/B/C.
        vecs[0]  = '{3'b111, 3'b001, 1'b1, 5'd5, 32'hA};
        vecs[1]  = '{3'b111, 3'b010, 1'b1, 5'd6, 32'hB};
        vecs[2]  = '{3'b111, 3'b100, 1'b1, 5'd7, 32'hC};
        vecs[3]  = '{3'b111, 3'b001, 1'b1, 5'd5, 32'hA};
        vecs[4]  = '{3'b111, 3'b010, 1'b1, 5'd6, 32'hB};
        vecs[5]  = '{3'b111, 3'b100, 1'b1, 5'd7, 32'hC};
        vecs[6]  = '{3'b000, 3'b000, 1'b0, 5'd7, 32'hC};
        vecs[7]  = '{3'b010, 3'b010, 1'b1, 5'd6, 32'hB};
        vecs[8]  = '{3'b101, 3'b100, 1'b1, 5'd7, 32'hC};
        vecs[9]  = '{3'b011, 3'b001, 1'b1, 5'd5, 32'hA};
        vecs[10] = '{3'b001, 3'b001, 1'b1, 5'd5, 32'hA};
        vecs[11] = '{3'b100, 3'b100, 1'b1, 5'd7, 32'hC};

        // Reset values.
        #1;
        chk("rst_wr_en", 64'(wr_en),     64'd0);
        chk("rst_addr",  64'(wr_addr),   64'd0);
        chk("rst_data",  64'(wr_data),   64'd0);
        chk("rst_done",  64'(init_done), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);

        // Release reset with everyone requesting: no grant during the clear.
        tick();
        rst_n     = 1'b1;
        req_valid = 3'b111;
        check_clear_seq(-1);
        #1;
        chk("first_grant", 64'(req_ready), 64'b001);

        // Table-driven round-robin vectors.
        for (int i = 0; i < 12; i++) begin
            req_valid = vecs[i].valid;
            #1;
            chk("tbl_ready", 64'(req_ready), 64'(vecs[i].exp_ready));
            tick();
            chk("tbl_wr_en", 64'(wr_en),   64'(vecs[i].exp_en));
            chk("tbl_addr",  64'(wr_addr), 64'(vecs[i].exp_addr));
            chk("tbl_data",  64'(wr_data), 64'(vecs[i].exp_data));
        end

        // Address 0: handshaken, not written; pointer still advances.
        req_addr[AW +: AW] = 5'd0;
        req_data[DW +: DW] = 32'hFFFF_FFFF;
        req_valid = 3'b010;
        #1;
        chk("x0_ready", 64'(req_ready), 64'b010);
        tick();
        chk("x0_wr_en", 64'(wr_en),   64'd0);
        chk("x0_addr",  64'(wr_addr), 64'd7);
        chk("x0_data",  64'(wr_data), 64'hC);

        // clr_req in the same cycle as a requester-2 grant.
        req_addr[2*AW +: AW] = 5'd9;
        req_data[2*DW +: DW] = 32'h55;
        req_valid = 3'b111;
        clr_req   = 1'b1;
        #1;
        chk("x0_next_grant", 64'(req_ready), 64'b100);
        tick();
        chk("clrrun_wr_en", 64'(wr_en),     64'd1);
        chk("clrrun_addr",  64'(wr_addr),   64'd9);
        chk("clrrun_data",  64'(wr_data),   64'h55);
        chk("clrrun_done",  64'(init_done), 64'd0);
        chk("clrrun_ready", 64'(req_ready), 64'd0);
        clr_req   = 1'b0;
        req_valid = 3'b000;
        // A clr_req pulse during this clear must not restart it.
        check_clear_seq(10);

        // One transfer, then an asynchronous reset between edges.
        req_valid = 3'b111;
        #1;
        chk("pre_rst_grant", 64'(req_ready), 64'b001);
        tick();
        chk("pre_rst_wr_en", 64'(wr_en), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 64'(wr_en),     64'd0);
        chk("arst_ready", 64'(req_ready), 64'd0);
        chk("arst_done",  64'(init_done), 64'd0);
        chk("arst_addr",  64'(wr_addr),   64'd0);
        #1;
        rst_n = 1'b1;
        check_clear_seq(-1);
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
